osc_ctrl: RTL and testbench

//  Programmable on-chip oscillator controller: derives a divided clock clk_out from clk, sequences run/stop

---
 rtl/osc_ctrl_pkg.sv | 13 +
 rtl/osc_ctrl_half_cnt.sv | 25 ++
 rtl/osc_ctrl.sv | 144 ++++++++++++++
 tb/tb_osc_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/osc_ctrl_pkg.sv
// Shared types and defaults for the programmable oscillator controller.
package osc_ctrl_pkg;

  localparam int unsigned DIV_W_DEF    = 8;
  localparam int unsigned DEF_HALF_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

endpackage

// File: rtl/osc_ctrl_half_cnt.sv
// Half-period counter: counts 0..limit-1 and wraps, flags the last count of a phase.
module osc_ctrl_half_cnt #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] limit,
  output logic             term_c
);

  logic [DIV_W-1:0] cnt;

  assign term_c = (cnt == (limit - DIV_W'(1)));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= term_c ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/osc_ctrl.sv
// Oscillator controller: run/stop sequencing of a divided clock with glitch-free
// stop and half-period reconfiguration through a req/ack handshake.
module osc_ctrl
  import osc_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned DEF_HALF = DEF_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             cfg_req,
  input  logic [DIV_W-1:0] cfg_half,
  output logic             cfg_ack,
  output logic             running,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick
);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cur_half, cur_half_d;
  logic [DIV_W-1:0] pend_half, pend_half_d;
  logic             pending, pending_d;
  logic             clk_out_d, rise_d, fall_d, ack_d;
  logic             term_c, cfg_take_c;
  logic [DIV_W-1:0] cfg_val_c;

  // A zero request behaves as one; a request is ignored while one is queued or just acked.
  assign cfg_val_c  = (cfg_half == '0) ? DIV_W'(1) : cfg_half;
  assign cfg_take_c = cfg_req && !cfg_ack && !pending;

  osc_ctrl_half_cnt #(.DIV_W(DIV_W)) u_half_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state_q == ST_IDLE) || (state_d == ST_IDLE)),
    .en     (state_q != ST_IDLE),
    .limit  (cur_half),
    .term_c (term_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_half  <= DIV_W'(DEF_HALF);
      pend_half <= '0;
      pending   <= 1'b0;
      clk_out   <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      cfg_ack   <= 1'b0;
      running   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_half  <= cur_half_d;
      pend_half <= pend_half_d;
      pending   <= pending_d;
      clk_out   <= clk_out_d;
      rise_tick <= rise_d;
      fall_tick <= fall_d;
      cfg_ack   <= ack_d;
      running   <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_half_d  = cur_half;
    pend_half_d = pend_half;
    pending_d   = pending;
    clk_out_d   = clk_out;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    ack_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        clk_out_d = 1'b0;
        // A value queued before a stop in the low phase is committed here.
        if (pending) begin
          cur_half_d = pend_half;
          pending_d  = 1'b0;
          ack_d      = 1'b1;
        end else if (cfg_take_c) begin
          cur_half_d = cfg_val_c;
          ack_d      = 1'b1;
        end
        if (run_req) begin
          state_d   = ST_RUN;
          clk_out_d = 1'b1;
          rise_d    = 1'b1;
        end
      end

      ST_RUN: begin
        if (cfg_take_c) begin
          pend_half_d = cfg_val_c;
          pending_d   = 1'b1;
        end
        if (!clk_out && !run_req) begin
          state_d = ST_IDLE;
        end else if (term_c) begin
          clk_out_d = !clk_out;
          if (clk_out) begin
            fall_d = 1'b1;
            if (pending) begin
              cur_half_d = pend_half;
              pending_d  = 1'b0;
              ack_d      = 1'b1;
            end
            if (!run_req) state_d = ST_IDLE;
          end else begin
            rise_d = 1'b1;
          end
        end else if (!run_req) begin
          state_d = ST_STOPPING;
        end
      end

      ST_STOPPING: begin
        if (cfg_take_c) begin
          pend_half_d = cfg_val_c;
          pending_d   = 1'b1;
        end
        if (term_c) begin
          state_d   = ST_IDLE;
          clk_out_d = 1'b0;
          fall_d    = 1'b1;
          if (pending) begin
            cur_half_d = pend_half;
            pending_d  = 1'b0;
            ack_d      = 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clk_out_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_osc_ctrl.sv
// Directed self-checking bench for osc_ctrl.
module tb_osc_ctrl;

  localparam int unsigned DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             run_req;
  logic             cfg_req;
  logic [DIV_W-1:0] cfg_half;
  logic             cfg_ack, running, clk_out, rise_tick, fall_tick;

  int errors = 0;
  int checks = 0;

  osc_ctrl #(.DIV_W(DIV_W), .DEF_HALF(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .run_req   (run_req),
    .cfg_req   (cfg_req),
    .cfg_half  (cfg_half),
    .cfg_ack   (cfg_ack),
    .running   (running),
    .clk_out   (clk_out),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: wait for the sampling edge, compare every output, act as cfg requester.
  task automatic cyc(input string tag, input bit ce, input bit re, input bit fe,
                     input bit ue, input bit ae);
    @(negedge clk);
    check({tag, "/clk_out"}, 32'(clk_out), 32'(ce));
    check({tag, "/rise"}, 32'(rise_tick), 32'(re));
    check({tag, "/fall"}, 32'(fall_tick), 32'(fe));
    check({tag, "/running"}, 32'(running), 32'(ue));
    check({tag, "/ack"}, 32'(cfg_ack), 32'(ae));
    if (cfg_ack) cfg_req = 1'b0;
  endtask

  // n cycles of a free-running wave with the given half-period, optionally starting low.
  task automatic wave(input string tag, input int half, input int n, input bit start_low,
                      input bit ack0);
    for (int k = 0; k < n; k++) begin
      bit hi, edge_k;
      hi     = (((k / half) + int'(start_low)) % 2) == 0;
      edge_k = (k % half) == 0;
      cyc($sformatf("%s[%0d]", tag, k), hi, edge_k && hi, edge_k && !hi, 1'b1,
          (k == 0) ? ack0 : 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; run_req = 1'b0; cfg_req = 1'b0; cfg_half = '0;
    repeat (2) @(negedge clk);
    cyc("reset", 0, 0, 0, 0, 0);

    // Default half-period 4 after reset.
    rst = 1'b0; run_req = 1'b1;
    wave("t1", 4, 16, 0, 0);
    // Stop requested on the last low cycle: straight to idle, no fall tick.
    run_req = 1'b0;
    cyc("t1stop", 0, 0, 0, 0, 0);

    // Zero half-period maps to 1.
    cfg_half = 8'd0; cfg_req = 1'b1;
    cyc("t2ack", 0, 0, 0, 0, 1);
    cyc("t2idle", 0, 0, 0, 0, 0);
    run_req = 1'b1;
    wave("t2", 1, 6, 0, 0);
    run_req = 1'b0;
    cyc("t2stop", 0, 0, 0, 0, 0);

    // Reconfigure 4 -> 6 mid-high: applied at the falling edge.
    cfg_half = 8'd4; cfg_req = 1'b1;
    cyc("t3cfg", 0, 0, 0, 0, 1);
    run_req = 1'b1;
    wave("t3old", 4, 2, 0, 0);
    cfg_half = 8'd6; cfg_req = 1'b1;
    cyc("t3pend2", 1, 0, 0, 1, 0);
    cyc("t3pend3", 1, 0, 0, 1, 0);
    wave("t3new", 6, 18, 1, 1);
    run_req = 1'b0;
    cyc("t3stop", 0, 0, 0, 0, 0);

    // Config and run in the same cycle from idle; stop during high at cnt=1.
    cfg_half = 8'd4; cfg_req = 1'b1; run_req = 1'b1;
    cyc("t4start", 1, 1, 0, 1, 1);
    cyc("t4c1", 1, 0, 0, 1, 0);
    run_req = 1'b0;
    cyc("t4c2", 1, 0, 0, 1, 0);
    cyc("t4c3", 1, 0, 0, 1, 0);
    run_req = 1'b1;
    cyc("t4fall", 0, 0, 1, 0, 0);
    // run_req raised while stopping: restart only after the stop completes.
    wave("t4restart", 4, 6, 0, 0);

    // Stop during the low phase (cnt=1).
    run_req = 1'b0;
    cyc("t5a", 0, 0, 0, 0, 0);
    cyc("t5b", 0, 0, 0, 0, 0);

    // Reset while running with a queued config.
    run_req = 1'b1;
    cyc("t6start", 1, 1, 0, 1, 0);
    cfg_half = 8'd9; cfg_req = 1'b1;
    cyc("t6c1", 1, 0, 0, 1, 0);
    rst = 1'b1;
    cyc("t6rst", 0, 0, 0, 0, 0);
    rst = 1'b0; cfg_req = 1'b0; run_req = 1'b0;
    cyc("t6idle", 0, 0, 0, 0, 0);
    run_req = 1'b1;
    wave("t6after", 4, 10, 0, 0);
    run_req = 1'b0;
    cyc("t6end", 1, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
